spi_slave_4byte: RTL and testbench

//  SPI slave (target) endpoint for 32-bit frames; counterpart of spi_master_4byte on the same four-wire bus.

---
 rtl/spi_slave_4byte_pkg.sv | 27 ++
 rtl/spi_slave_4byte_sync_edge.sv | 34 +++
 rtl/spi_slave_4byte.sv | 155 +++++++++++++++
 tb/tb_spi_slave_4byte.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_4byte_pkg.sv
// Shared definitions for the SPI slave: frame width, latched mode layout,
// FSM states and clock-edge classification helpers.
`timescale 1ns/1ps
package spi_slave_4byte_pkg;

  localparam int SPI_WIDTH = 32;

  // Latched mode is stored as {CPOL, CPHA}
  localparam int MODE_CPOL_BIT = 1;
  localparam int MODE_CPHA_BIT = 0;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } spi_state_e;

  // Leading edge moves SPI_CLK away from its idle (CPOL) level
  function automatic logic lead_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? fall : rise;
  endfunction

  // Trailing edge returns SPI_CLK to its idle (CPOL) level
  function automatic logic trail_edge(input logic cpol, input logic rise, input logic fall);
    return cpol ? rise : fall;
  endfunction

endpackage

// File: rtl/spi_slave_4byte_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level and its delayed copy.
`timescale 1ns/1ps
module spi_slave_4byte_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw pin through the synchronizer and keep one delayed copy for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_4byte.sv
// SPI slave endpoint for WIDTH-bit MSB-first frames in all four CPOL/CPHA modes.
// SPI pins are oversampled in the CLK_IN domain; each completed word is
// presented on dout with a one-cycle valid pulse, and din is returned on MISO.
`timescale 1ns/1ps
module spi_slave_4byte
  import spi_slave_4byte_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic             SPI_CLK,
  input  logic             SPI_SS,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_EN,
  input  logic             CPOL,
  input  logic             CPHA,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  // Synchronized pin levels and edge pulses
  logic clk_rise, clk_fall, clk_lvl_unused;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_slave_4byte_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk_i (CLK_IN), .rst_i (RST), .d_i (SPI_CLK),
    .q_o (clk_lvl_unused), .rise_o (clk_rise), .fall_o (clk_fall)
  );

  spi_slave_4byte_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk_i (CLK_IN), .rst_i (RST), .d_i (SPI_SS),
    .q_o (ss_lvl), .rise_o (ss_rise), .fall_o (ss_fall)
  );

  spi_slave_4byte_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i (CLK_IN), .rst_i (RST), .d_i (MOSI),
    .q_o (mosi_lvl), .rise_o (mosi_rise_unused), .fall_o (mosi_fall_unused)
  );

  spi_state_e        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  rx_q, rx_d;
  logic [WIDTH-1:0]  tx_q, tx_d;
  logic              miso_q, miso_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic lead, trail, sample_edge, shift_edge;

  // Classify SPI_CLK edges with the mode latched at frame start
  assign lead        = lead_edge(mode_q[MODE_CPOL_BIT], clk_rise, clk_fall);
  assign trail       = trail_edge(mode_q[MODE_CPOL_BIT], clk_rise, clk_fall);
  assign sample_edge = mode_q[MODE_CPHA_BIT] ? trail : lead;
  assign shift_edge  = mode_q[MODE_CPHA_BIT] ? lead  : trail;

  // Next-state logic: frame start, bit sampling/shifting, word wrap and frame end
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    valid_d = done_q;
    err_d   = 1'b0;

    // The word is published one cycle after its final sample edge
    if (done_q) dout_d = rx_q;

    case (state_q)
      S_IDLE: begin
        if (ss_fall) begin
          mode_d  = {CPOL, CPHA};
          cnt_d   = '0;
          miso_d  = din[WIDTH-1];
          // tx holds the bits still to be driven; with CPHA=0 the MSB is already on MISO
          tx_d    = CPHA ? din : {din[WIDTH-2:0], 1'b0};
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sample_edge) begin
          rx_d = {rx_q[WIDTH-2:0], mosi_lvl};
          if (cnt_q == LAST_BIT) begin
            cnt_d  = '0;
            done_d = 1'b1;
            tx_d   = din;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (shift_edge) begin
          miso_d = tx_q[WIDTH-1];
          tx_d   = {tx_q[WIDTH-2:0], 1'b0};
        end
        // A word completing on this same cycle leaves cnt_d at zero, so no error
        if (ss_rise) begin
          state_d = S_IDLE;
          err_d   = (cnt_d != '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign MISO      = miso_q;
  assign MISO_EN   = ~ss_lvl;
  assign dout      = dout_q;
  assign valid     = valid_q;
  assign busy      = (state_q == S_SHIFT);
  assign frame_err = err_q;

endmodule

// File: tb/tb_spi_slave_4byte.sv
// Bench for spi_slave_4byte: an SPI master model drives frames, a monitor
// collects published words, and a scoreboard matches them against expectations.
`timescale 1ns/1ps
module tb_spi_slave_4byte;

  localparam time HALF = 60ns;

  logic        CLK_IN = 1'b0;
  logic        RST, SPI_CLK, SPI_SS, MOSI, CPOL, CPHA;
  logic        MISO, MISO_EN, valid, busy, frame_err;
  logic [31:0] din, dout;

  spi_slave_4byte #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .CLK_IN (CLK_IN), .RST (RST), .SPI_CLK (SPI_CLK), .SPI_SS (SPI_SS),
    .MOSI (MOSI), .MISO (MISO), .MISO_EN (MISO_EN), .CPOL (CPOL), .CPHA (CPHA),
    .din (din), .dout (dout), .valid (valid), .busy (busy), .frame_err (frame_err)
  );

  always #5ns CLK_IN = ~CLK_IN;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          valid_cnt = 0;
  int          err_cnt   = 0;
  int          busy_cnt  = 0;
  time         t_valid   = 0;
  time         t_sample  = 0;

  // Monitor: capture every published word and count pulses
  always @(negedge CLK_IN) begin
    if (valid) begin
      got_q.push_back(dout);
      valid_cnt <= valid_cnt + 1;
      t_valid   <= $time;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Match published words against expectations in order, then require both queues empty
  task automatic sb_drain(input string name);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [31:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({name, "_dout"}, 64'(g), 64'(e));
    end
    check({name, "_missing_valid"}, 64'(exp_q.size()), 64'd0);
    check({name, "_extra_valid"},   64'(got_q.size()), 64'd0);
    exp_q.delete();
    got_q.delete();
  endtask

  // SPI master model; din switches to din_next at bit 16, RST asserted at rst_bit (-1 = never)
  task automatic spi_xfer(input logic cpol, input logic cpha, input logic [63:0] mtx,
                          input int nbits, input logic [31:0] din_next, input int rst_bit,
                          output logic [63:0] mrx);
    mrx = '0;
    @(negedge CLK_IN);
    CPOL = cpol; CPHA = cpha; SPI_CLK = cpol;
    #HALF;
    SPI_SS = 1'b0;
    if (!cpha) MOSI = mtx[nbits-1];
    #HALF;
    check("miso_en_active", 64'(MISO_EN), 64'd1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        RST = 1'b1;
        @(posedge CLK_IN); #1;
        check("rst_midframe_outputs", {27'd0, MISO, MISO_EN, valid, busy, frame_err, dout}, 64'd0);
        SPI_SS = 1'b1; SPI_CLK = cpol; MOSI = 1'b0;
        repeat (3) @(negedge CLK_IN);
        RST = 1'b0;
        #HALF;
        return;
      end
      if (i == 16) din = din_next;
      SPI_CLK = ~cpol;
      if (cpha) MOSI = mtx[nbits-1-i];
      else begin
        mrx = {mrx[62:0], MISO};
        if (i % 32 == 31) t_sample = $time;
      end
      #HALF;
      SPI_CLK = cpol;
      if (cpha) begin
        mrx = {mrx[62:0], MISO};
        if (i % 32 == 31) t_sample = $time;
      end else if (i + 1 < nbits) MOSI = mtx[nbits-2-i];
      else MOSI = 1'b0;
      #HALF;
    end
    SPI_SS = 1'b1;
    #HALF; #HALF;
  endtask

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [31:0] mword;     // master -> slave
    logic [31:0] sdin;      // slave din
    logic [31:0] exp_dout;  // expected slave dout
    logic [31:0] exp_mrx;   // expected word seen by master on MISO
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] mrx;
    int v0, e0, b0;

    vecs[0] = '{1'b0, 1'b0, 32'haaaa3333, 32'h12345678, 32'haaaa3333, 32'h12345678};
    vecs[1] = '{1'b0, 1'b1, 32'hbbbb4444, 32'h9abcdef0, 32'hbbbb4444, 32'h9abcdef0};
    vecs[2] = '{1'b1, 1'b0, 32'hcccc5555, 32'h0f1e2d3c, 32'hcccc5555, 32'h0f1e2d3c};
    vecs[3] = '{1'b1, 1'b1, 32'hdddd6666, 32'h55aa55aa, 32'hdddd6666, 32'h55aa55aa};
    vecs[4] = '{1'b0, 1'b0, 32'h80000001, 32'hffffffff, 32'h80000001, 32'hffffffff};
    vecs[5] = '{1'b1, 1'b1, 32'hffffffff, 32'h00000001, 32'hffffffff, 32'h00000001};

    RST = 1'b1; SPI_CLK = 1'b0; SPI_SS = 1'b1; MOSI = 1'b0;
    CPOL = 1'b0; CPHA = 1'b0; din = '0;
    repeat (3) @(negedge CLK_IN);
    check("reset_outputs", {27'd0, MISO, MISO_EN, valid, busy, frame_err, dout}, 64'd0);
    RST = 1'b0;
    repeat (3) @(negedge CLK_IN);

    // Single frames in every mode
    foreach (vecs[k]) begin
      din = vecs[k].sdin;
      exp_q.push_back(vecs[k].exp_dout);
      v0 = valid_cnt; e0 = err_cnt;
      spi_xfer(vecs[k].cpol, vecs[k].cpha, {32'd0, vecs[k].mword}, 32, vecs[k].sdin, -1, mrx);
      check($sformatf("v%0d_master_rx", k), mrx, {32'd0, vecs[k].exp_mrx});
      check($sformatf("v%0d_valid_count", k), 64'(valid_cnt - v0), 64'd1);
      check($sformatf("v%0d_frame_err", k), 64'(err_cnt - e0), 64'd0);
      check($sformatf("v%0d_latency", k), 64'(t_valid - t_sample), 64'(40ns));
      check($sformatf("v%0d_idle", k), {62'd0, busy, MISO_EN}, 64'd0);
      sb_drain($sformatf("v%0d", k));
    end

    // Back-to-back words in one SS low; din changed mid-word is picked up at the wrap
    din = 32'h11112222;
    exp_q.push_back(32'h0000ffff);
    exp_q.push_back(32'hffff0000);
    v0 = valid_cnt; e0 = err_cnt;
    spi_xfer(1'b0, 1'b0, 64'h0000ffff_ffff0000, 64, 32'h33334444, -1, mrx);
    check("b2b_master_rx", mrx, 64'h11112222_33334444);
    check("b2b_valid_count", 64'(valid_cnt - v0), 64'd2);
    check("b2b_frame_err", 64'(err_cnt - e0), 64'd0);
    sb_drain("b2b");

    // Partial frame: 13 bits then SS released
    din = 32'h01020304;
    v0 = valid_cnt; e0 = err_cnt;
    spi_xfer(1'b0, 1'b0, 64'h0000_0000_0000_1555, 13, 32'h01020304, -1, mrx);
    check("partial_frame_err", 64'(err_cnt - e0), 64'd1);
    check("partial_valid_count", 64'(valid_cnt - v0), 64'd0);
    check("partial_dout_held", 64'(dout), 64'hffff0000);
    check("partial_busy", 64'(busy), 64'd0);
    sb_drain("partial");

    // Reset at bit 20, then a clean frame
    din = 32'h76543210;
    v0 = valid_cnt;
    spi_xfer(1'b0, 1'b0, 64'h12121212, 32, 32'h76543210, 20, mrx);
    check("rst_abort_no_valid", 64'(valid_cnt - v0), 64'd0);
    din = 32'hcafef00d;
    exp_q.push_back(32'hdeadbeef);
    v0 = valid_cnt; e0 = err_cnt;
    spi_xfer(1'b0, 1'b0, 64'hdeadbeef, 32, 32'hcafef00d, -1, mrx);
    check("post_rst_master_rx", mrx, 64'hcafef00d);
    check("post_rst_valid_count", 64'(valid_cnt - v0), 64'd1);
    check("post_rst_frame_err", 64'(err_cnt - e0), 64'd0);
    sb_drain("post_rst");

    // SPI_CLK activity while SS is high must be ignored
    @(negedge CLK_IN);
    v0 = valid_cnt; e0 = err_cnt; b0 = busy_cnt;
    for (int i = 0; i < 20; i++) begin
      SPI_CLK = ~SPI_CLK;
      MOSI = 1'($urandom_range(0, 1));
      #HALF;
    end
    SPI_CLK = 1'b0;
    #HALF;
    check("glitch_valid", 64'(valid_cnt - v0), 64'd0);
    check("glitch_busy", 64'(busy_cnt - b0), 64'd0);
    check("glitch_frame_err", 64'(err_cnt - e0), 64'd0);
    check("glitch_dout_held", 64'(dout), 64'hdeadbeef);
    sb_drain("glitch");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
